// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        EX_WAIT  = 2'd1,
        REDIRECT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_fwd_unit.sv
// E-stage operand forwarding select for one source operand.
import pipe_ctrl_pkg::*;

module pipe_fwd_unit (
    input  logic [4:0] rs,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       regwrite_M,
    input  logic       regwrite_W,
    output fwd_sel_t   sel
);

    // M holds the younger result, so it wins when both stages match.
    always_comb begin
        sel = FWD_RF;
        if (regwrite_M && rd_M != REG_X0 && rd_M == rs)
            sel = FWD_M;
        else if (regwrite_W && rd_W != REG_X0 && rd_W == rs)
            sel = FWD_W;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline.
// Optional perf counters are built only when HAZARD_PERF_EN is defined.
//
// state    | meaning
// RUN      | normal issue, single-cycle hazards only
// EX_WAIT  | multi-cycle execute op in flight, front end held
// REDIRECT | holding flush_D while the redirected fetch arrives
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1_D,
    input  logic [4:0]      rs2_D,
    input  logic [4:0]      rs1_E,
    input  logic [4:0]      rs2_E,
    input  logic [4:0]      rd_E,
    input  logic [4:0]      rd_M,
    input  logic [4:0]      rd_W,
    input  logic            regwrite_E,
    input  logic            regwrite_M,
    input  logic            regwrite_W,
    input  logic            memread_E,
    input  logic            redirect_E,
    input  logic            ex_start,
    input  logic            ex_done,
    input  logic            imem_ready,
    input  logic            dmem_ready,
    output logic            stall_F,
    output logic            stall_D,
    output logic            stall_E,
    output logic            stall_M,
    output logic            flush_D,
    output logic            flush_E,
    output logic            flush_M,
    output logic            flush_W,
    output logic [1:0]      fwd_a_E,
    output logic [1:0]      fwd_b_E,
    output logic [XLEN-1:0] perf_stall_cnt,
    output logic [XLEN-1:0] perf_flush_cnt
);

    localparam logic [2:0] RELOAD = 3'(FLUSH_DEPTH - 1);

    hz_state_t  state;
    logic [2:0] redir_cnt;
    logic       lu_bubble;
    logic       redir_act;
    logic       ex_wait;
    logic       load_use;
    logic       lu_take;
    fwd_sel_t   sel_a;
    fwd_sel_t   sel_b;

    pipe_fwd_unit u_fwd_a (
        .rs         (rs1_E),
        .rd_M       (rd_M),
        .rd_W       (rd_W),
        .regwrite_M (regwrite_M),
        .regwrite_W (regwrite_W),
        .sel        (sel_a)
    );

    pipe_fwd_unit u_fwd_b (
        .rs         (rs2_E),
        .rd_M       (rd_M),
        .rd_W       (rd_W),
        .regwrite_M (regwrite_M),
        .regwrite_W (regwrite_W),
        .sel        (sel_b)
    );

    assign fwd_a_E = rst ? sel_a : FWD_RF;
    assign fwd_b_E = rst ? sel_b : FWD_RF;

    assign redir_act = redirect_E || (state == REDIRECT);
    assign ex_wait   = (state == EX_WAIT) || (ex_start && !ex_done);
    // lu_bubble limits a load-use hazard to a single inserted bubble.
    assign load_use  = memread_E && (rd_E != REG_X0) &&
                       ((rd_E == rs1_D) || (rd_E == rs2_D)) && !lu_bubble;

    always_comb begin
        stall_F = 1'b0;
        stall_D = 1'b0;
        stall_E = 1'b0;
        stall_M = 1'b0;
        flush_D = 1'b0;
        flush_E = 1'b0;
        flush_M = 1'b0;
        flush_W = 1'b0;
        lu_take = 1'b0;
        if (!rst) begin
            flush_D = 1'b1;
            flush_E = 1'b1;
            flush_M = 1'b1;
            flush_W = 1'b1;
        end else if (!dmem_ready) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            stall_M = 1'b1;
            flush_W = 1'b1;
        end else if (redir_act) begin
            flush_D = 1'b1;
            flush_E = redirect_E;
        end else if (ex_wait) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            stall_E = 1'b1;
            flush_M = 1'b1;
        end else if (load_use) begin
            stall_F = 1'b1;
            stall_D = 1'b1;
            flush_E = 1'b1;
            lu_take = 1'b1;
        end else if (!imem_ready) begin
            stall_F = 1'b1;
            flush_D = 1'b1;
        end
    end

    // A data-memory wait freezes everything so pending events replay afterwards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            redir_cnt <= 3'd0;
            lu_bubble <= 1'b0;
        end else if (dmem_ready) begin
            lu_bubble <= lu_take;
            if (redirect_E) begin
                if (FLUSH_DEPTH > 1) begin
                    state     <= REDIRECT;
                    redir_cnt <= RELOAD;
                end else begin
                    state     <= RUN;
                    redir_cnt <= 3'd0;
                end
            end else begin
                case (state)
                    RUN: begin
                        if (ex_start && !ex_done)
                            state <= EX_WAIT;
                    end
                    EX_WAIT: begin
                        if (ex_done)
                            state <= RUN;
                    end
                    REDIRECT: begin
                        if (redir_cnt <= 3'd1) begin
                            state     <= RUN;
                            redir_cnt <= 3'd0;
                        end else begin
                            redir_cnt <= redir_cnt - 3'd1;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_F)
                perf_stall_cnt <= perf_stall_cnt + XLEN'(1);
            if (redirect_E && dmem_ready)
                perf_flush_cnt <= perf_flush_cnt + XLEN'(1);
        end
    end
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (FLUSH_DEPTH=3).
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [4:0]      rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
    logic            regwrite_E, regwrite_M, regwrite_W, memread_E, redirect_E;
    logic            ex_start, ex_done, imem_ready, dmem_ready;
    logic            stall_F, stall_D, stall_E, stall_M;
    logic            flush_D, flush_E, flush_M, flush_W;
    logic [1:0]      fwd_a_E, fwd_b_E;
    logic [XLEN-1:0] perf_stall_cnt, perf_flush_cnt;

    int n_chk  = 0;
    int n_fail = 0;

    pipe_hazard_ctrl #(.FLUSH_DEPTH(3), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
        .rd_E(rd_E), .rd_M(rd_M), .rd_W(rd_W),
        .regwrite_E(regwrite_E), .regwrite_M(regwrite_M), .regwrite_W(regwrite_W),
        .memread_E(memread_E), .redirect_E(redirect_E),
        .ex_start(ex_start), .ex_done(ex_done),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
        .flush_D(flush_D), .flush_E(flush_E), .flush_M(flush_M), .flush_W(flush_W),
        .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    // {stall_F,stall_D,stall_E,stall_M, flush_D,flush_E,flush_M,flush_W}
    function automatic logic [7:0] ctl();
        return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_M, flush_W};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0;
        rd_E = 0; rd_M = 0; rd_W = 0;
        regwrite_E = 0; regwrite_M = 0; regwrite_W = 0;
        memread_E = 0; redirect_E = 0; ex_start = 0; ex_done = 0;
        imem_ready = 1; dmem_ready = 1;
    endtask

    // Advance to 1ns after the next rising edge; checks follow a 2ns settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b0;
        #3;
        check("reset_ctl", ctl(), 8'b0000_1111);
        check("reset_fwd", {fwd_a_E, fwd_b_E}, 4'b0000);
        #4 rst = 1'b1;
        tick(); #2;
        check("idle_ctl", ctl(), 8'b0000_0000);

        // Forwarding
        rs1_E = 7; rs2_E = 7; rd_M = 7; rd_W = 7; regwrite_M = 1; regwrite_W = 1;
        #2 check("fwd_m_prio", {fwd_a_E, fwd_b_E}, 4'b1010);
        regwrite_M = 0;
        #2 check("fwd_w", {fwd_a_E, fwd_b_E}, 4'b0101);
        rd_W = 0; rs1_E = 0; rs2_E = 0;
        #2 check("fwd_x0", {fwd_a_E, fwd_b_E}, 4'b0000);
        rs2_E = 9; rd_M = 9; regwrite_M = 1;
        #2 check("fwd_b_only", {fwd_a_E, fwd_b_E}, 4'b0010);
        idle();

        // Load-use: one bubble even if inputs are held
        tick();
        memread_E = 1; rd_E = 5; rs1_D = 5;
        #2 check("lu_stall", ctl(), 8'b1100_0100);
        tick(); #2;
        check("lu_one_bubble", ctl(), 8'b0000_0000);
        idle(); tick();
        memread_E = 1; rd_E = 6; rs2_D = 6;
        #2 check("lu_rs2", ctl(), 8'b1100_0100);
        idle(); tick();
        memread_E = 1; rd_E = 0; rs1_D = 0;
        #2 check("lu_x0", ctl(), 8'b0000_0000);
        idle();

        // IMEM wait
        imem_ready = 0;
        #2 check("imem_wait", ctl(), 8'b1000_1000);
        idle();

        // Redirect with simultaneous load-use: no stall
        tick();
        redirect_E = 1; memread_E = 1; rd_E = 5; rs1_D = 5;
        #2 check("redir_c0", ctl(), 8'b0000_1100);
        tick(); idle(); #2;
        check("redir_c1", ctl(), 8'b0000_1000);
        tick(); #2;
        check("redir_c2", ctl(), 8'b0000_1000);
        tick(); #2;
        check("redir_done", ctl(), 8'b0000_0000);

        // DMEM wait freezes REDIRECT counter
        redirect_E = 1;
        #2 check("dm_redir_c0", ctl(), 8'b0000_1100);
        tick(); redirect_E = 0; dmem_ready = 0; #2;
        check("dm_wait_1", ctl(), 8'b1111_0001);
        tick(); #2;
        check("dm_wait_2", ctl(), 8'b1111_0001);
        tick(); dmem_ready = 1; #2;
        check("dm_resume_1", ctl(), 8'b0000_1000);
        tick(); #2;
        check("dm_resume_2", ctl(), 8'b0000_1000);
        tick(); #2;
        check("dm_done", ctl(), 8'b0000_0000);

        // Reset in the middle of EX_WAIT
        ex_start = 1;
        #2 check("ex_rst_t0", ctl(), 8'b1110_0010);
        tick(); ex_start = 0; #2;
        check("ex_rst_wait", ctl(), 8'b1110_0010);
        rst = 1'b0;
        #1 check("ex_rst_async", ctl(), 8'b0000_1111);
        check("perf_rst", perf_stall_cnt, 0);
        @(negedge clk); rst = 1'b1;
        tick(); #2;
        check("ex_rst_run", ctl(), 8'b0000_0000);

        // EX handshake: t0..t4 stalled, release at t5
        ex_start = 1;
        #2 check("ex_t0", ctl(), 8'b1110_0010);
        for (int t = 1; t <= 3; t++) begin
            tick(); ex_start = 0; #2;
            check($sformatf("ex_t%0d", t), ctl(), 8'b1110_0010);
        end
        tick(); ex_done = 1; #2;
        check("ex_t4", ctl(), 8'b1110_0010);
        tick(); ex_done = 0; #2;
        check("ex_t5", ctl(), 8'b0000_0000);
`ifdef HAZARD_PERF_EN
        check("perf_stall", perf_stall_cnt, 5);
`else
        check("perf_stall_off", perf_stall_cnt, 0);
`endif

        // redirect_E and ex_start together: redirect wins, no EX_WAIT
        redirect_E = 1; ex_start = 1;
        #2 check("rx_c0", ctl(), 8'b0000_1100);
        tick(); idle(); #2;
        check("rx_c1", ctl(), 8'b0000_1000);
        tick(); #2;
        check("rx_c2", ctl(), 8'b0000_1000);
        tick(); #2;
        check("rx_done", ctl(), 8'b0000_0000);
`ifdef HAZARD_PERF_EN
        check("perf_flush", perf_flush_cnt, 1);
`else
        check("perf_flush_off", perf_flush_cnt, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline.
- Drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage operand forwarding muxes.
- Sequences multi-cycle events: branch/jump redirect flush, multi-cycle execute unit wait, instruction/data memory wait.
- Purely control; no datapath storage.

Parameters:
- FLUSH_DEPTH, 1, number of cycles flush_D is held after a redirect (covers instruction-memory latency); legal 1..7.
- XLEN, 32, width of perf counters.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- rs1_D, rs2_D  in  5  source registers of the instruction in D
- rs1_E, rs2_E  in  5  source registers of the instruction in E
- rd_E, rd_M, rd_W  in  5  destination registers per stage
- regwrite_E, regwrite_M, regwrite_W  in  1  stage writes rd
- memread_E  in  1  instruction in E is a load
- redirect_E  in  1  taken branch/jump resolved in E
- ex_start  in  1  multi-cycle unit accepted an op this cycle
- ex_done  in  1  multi-cycle unit result valid this cycle
- imem_ready  in  1  fetch data valid
- dmem_ready  in  1  data memory access completes this cycle
- stall_F, stall_D, stall_E, stall_M  out  1  hold stage register
- flush_D, flush_E, flush_M, flush_W  out  1  load bubble into stage register
- fwd_a_E, fwd_b_E  out  2  forwarding select: 00 regfile, 01 from W, 10 from M
- perf_stall_cnt, perf_flush_cnt  out  XLEN  perf counters

Behaviour:
- Reset (rst low, async): state=RUN, redirect counter=0, perf counters=0. All stall_*=0, all flush_*=1, fwd_*=00. Applies mid-operation and overrides every event.
- Stall/flush outputs are combinational from current inputs plus registered state (zero-cycle latency). FSM updates on the rising clk edge.
- Forwarding, independent of stalls:
  - fwd_a_E=10 if regwrite_M && rd_M!=0 && rd_M==rs1_E;
  - else 01 if regwrite_W && rd_W!=0 && rd_W==rs1_E;
  - else 00.
  - fwd_b_E uses the same rule with rs2_E. M has priority when M and W both match.
- Event priority, highest first:
  1. DMEM wait (dmem_ready=0): stall_F/D/E/M=1, flush_W=1, all other flushes 0. FSM frozen (no state or counter change); pending redirect/EX events are re-evaluated after.
  2. Redirect (redirect_E=1, or state REDIRECT): flush_D=1. In the redirect_E cycle also flush_E=1. Load-use is suppressed.
  3. EX wait (state EX_WAIT, or ex_start && !ex_done): stall_F/D/E=1, flush_M=1.
  4. Load-use (memread_E && rd_E!=0 && (rd_E==rs1_D || rd_E==rs2_D)): stall_F=1, stall_D=1, flush_E=1. Exactly one bubble.
  5. IMEM wait (imem_ready=0, no higher event): stall_F=1, flush_D=1.
  6. Otherwise all 0.
- FSM:
  - RUN->REDIRECT on redirect_E when FLUSH_DEPTH>1; counter=FLUSH_DEPTH-1. Decrement each unstalled cycle; at 1 -> RUN.
  - RUN->EX_WAIT on ex_start && !ex_done.
  - EX_WAIT->RUN on ex_done; the ex_done cycle is still stalled, with release on the next edge.
  - redirect_E and ex_start in the same cycle: redirect wins; ex_start is ignored (the op is squashed by flush_E).
  - redirect_E while in REDIRECT: counter reloads to FLUSH_DEPTH-1.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - perf_stall_cnt increments every cycle stall_F=1.
  - perf_flush_cnt increments on each redirect_E cycle.
  - Both wrap at 2^XLEN and reset to 0.
- Undefined: both ports are driven constant 0; no counter flops exist.

Decomposition:
- Package pipe_ctrl_pkg:
  - fwd_sel_t enum (FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10);
  - hz_state_t enum (RUN, EX_WAIT, REDIRECT);
  - REG_X0 constant 5'd0.
- One natural sub-module, pipe_fwd_unit: combinational forwarding compare, instantiated once per operand.

Test Plan:
- Reset mid-EX_WAIT: ex_start=1, then rst low for 1 cycle -> immediate flush_*=1, stall_*=0; after release state RUN, stall_F=0.
- Load-use: memread_E=1, rd_E=5, rs1_D=5 -> stall_F=stall_D=flush_E=1 for exactly 1 cycle. The same case with rd_E=0 gives no stall.
- Forwarding: rd_M=rd_W=7, both regwrite, rs1_E=7, rs2_E=7 -> fwd_a_E=fwd_b_E=10. With regwrite_M=0 -> 01.
- Redirect with FLUSH_DEPTH=3: redirect_E pulse -> flush_D high 3 cycles, flush_E high 1 cycle. A load-use hazard in the same cycle gives no stall.
- DMEM wait during REDIRECT: dmem_ready=0 for 2 cycles mid-flush -> all stalls=1, flush_W=1, counter frozen; flush_D resumes for the remaining cycles.
- EX handshake: ex_start at t0, ex_done at t4 -> stall_F/D/E=1 and flush_M=1 for t0..t4, clear at t5. With HAZARD_PERF_EN, perf_stall_cnt=5.
